// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one RV32I load/store at a time over valid/ready,
// performs it on an internal word array after LATENCY cycles, returns data/error.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned AW     = DEPTH_LOG2 + 2;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned NLANES = DATA_WIDTH / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_we;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_funct3;
  logic                  r_req_ready;
  logic                  w_req_ready_nxt;
  logic                  r_resp_valid;
  logic                  w_resp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic                  w_accept;
  logic                  w_do_access;
  logic                  w_mem_we;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_load;
  logic [NLANES-1:0]     w_wmask;
  logic [DATA_WIDTH-1:0] w_wrep;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_unused_addr_hi;

  // Address bits above the array size wrap and are deliberately dropped.
  assign w_unused_addr_hi = ^req_addr[DATA_WIDTH-1:AW];

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // Decode of the latched request: error, load extraction and store lane merge.
  always_comb begin
    w_idx   = r_addr[AW-1:2];
    w_word  = r_mem[w_idx];
    w_byte  = 8'(w_word >> {r_addr[1:0], 3'b000});
    w_half  = 16'(w_word >> {r_addr[1], 4'b0000});
    w_err   = 1'b0;
    w_load  = '0;
    w_wmask = '0;
    w_wrep  = r_wdata;
    case (r_funct3)
      F3_B: begin
        w_load  = {{24{w_byte[7]}}, w_byte};
        w_wmask = 4'b0001 << r_addr[1:0];
        w_wrep  = {4{r_wdata[7:0]}};
      end
      F3_BU: begin
        w_load  = {24'd0, w_byte};
        w_wmask = 4'b0001 << r_addr[1:0];
        w_wrep  = {4{r_wdata[7:0]}};
      end
      F3_H: begin
        w_err   = r_addr[0];
        w_load  = {{16{w_half[15]}}, w_half};
        w_wmask = 4'b0011 << {r_addr[1], 1'b0};
        w_wrep  = {2{r_wdata[15:0]}};
      end
      F3_HU: begin
        w_err   = r_addr[0];
        w_load  = {16'd0, w_half};
        w_wmask = 4'b0011 << {r_addr[1], 1'b0};
        w_wrep  = {2{r_wdata[15:0]}};
      end
      F3_W: begin
        w_err   = |r_addr[1:0];
        w_load  = w_word;
        w_wmask = 4'b1111;
      end
      default: w_err = 1'b1;
    endcase
    if (w_err || r_we) begin
      w_load = '0;
    end
    for (int i = 0; i < int'(NLANES); i++) begin
      w_merged[8*i +: 8] = w_wmask[i] ? w_wrep[8*i +: 8] : w_word[8*i +: 8];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_req_ready_nxt  = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_rdata_nxt      = r_rdata;
    w_err_nxt        = r_err;
    w_do_access      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid) begin
          w_state_nxt     = S_WAIT;
          w_cnt_nxt       = CNT_W'(LATENCY - 1);
          w_req_ready_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_do_access      = 1'b1;
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_rdata_nxt      = w_load;
          w_err_nxt        = w_err;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        w_resp_valid_nxt = 1'b1;
        if (resp_ready) begin
          w_state_nxt      = S_IDLE;
          w_resp_valid_nxt = 1'b0;
          w_req_ready_nxt  = 1'b1;
          w_rdata_nxt      = '0;
          w_err_nxt        = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_rdata      <= w_rdata_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Request capture; only sampled on accept, so later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_addr   <= req_addr[AW-1:0];
      r_wdata  <= req_wdata;
      r_funct3 <= req_funct3;
    end
  end

  // Array is never reset; a store commits exactly once, on the WAIT->RESP edge.
  assign w_mem_we = w_do_access && r_we && !w_err;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses queued at request time,
// compared when the response handshake happens.
module tb_data_mem_responder;

  localparam int unsigned LATENCY = 2;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  exp_t q[$];
  int   n_checks;
  int   n_errors;

  data_mem_responder #(
    .DATA_WIDTH(32),
    .DEPTH_LOG2(10),
    .LATENCY   (LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; during stall cycles a conflicting store is offered and must be ignored.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic [31:0] exp_d, input logic exp_e,
                      input int stall);
    int   n;
    exp_t e;
    q.push_back('{d: exp_d, e: exp_e});
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    #1;
    check("ready_low_after_accept", 32'(req_ready), 32'd0);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(LATENCY));
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_rdata", resp_rdata, q[0].d);
      check("stall_ready", 32'(req_ready), 32'd0);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = addr;
      req_wdata  = ~wdata;
      req_funct3 = 3'b010;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    e = q.pop_front();
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("rdata", resp_rdata, e.d);
    check("err", 32'(resp_err), 32'(e.e));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("valid_drop", 32'(resp_valid), 32'd0);
    check("ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Word store/load
    xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 0);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 0);
    // Byte lanes and sign/zero extension
    xact(1'b1, 32'h11, 32'h00000055, 3'b000, 32'h0, 1'b0, 0);
    xact(1'b0, 32'h11, 32'h0, 3'b000, 32'h00000055, 1'b0, 0);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 0);
    xact(1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0, 0);
    xact(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0, 0);
    // Halfword lanes
    xact(1'b1, 32'h20, 32'h12345678, 3'b010, 32'h0, 1'b0, 0);
    xact(1'b1, 32'h22, 32'hFFFF8001, 3'b001, 32'h0, 1'b0, 0);
    xact(1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF8001, 1'b0, 0);
    xact(1'b0, 32'h22, 32'h0, 3'b101, 32'h00008001, 1'b0, 0);
    xact(1'b0, 32'h20, 32'h0, 3'b010, 32'h80015678, 1'b0, 0);
    xact(1'b0, 32'h20, 32'h0, 3'b001, 32'h00005678, 1'b0, 0);
    xact(1'b0, 32'h21, 32'h0, 3'b000, 32'h00000056, 1'b0, 0);
    // Errors leave memory untouched
    xact(1'b0, 32'h11, 32'h0, 3'b010, 32'h0, 1'b1, 0);
    xact(1'b1, 32'h13, 32'h0000FFFF, 3'b001, 32'h0, 1'b1, 0);
    xact(1'b1, 32'h12, 32'h00000000, 3'b010, 32'h0, 1'b1, 0);
    xact(1'b1, 32'h10, 32'h00000000, 3'b011, 32'h0, 1'b1, 0);
    xact(1'b0, 32'h10, 32'h0, 3'b110, 32'h0, 1'b1, 0);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 0);
    // Response stall with competing requests
    xact(1'b1, 32'h30, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0, 5);
    xact(1'b0, 32'h30, 32'h0, 3'b010, 32'hA5A5A5A5, 1'b0, 3);

    // Reset during WAIT drops the store
    xact(1'b1, 32'h40, 32'h11111111, 3'b010, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h40;
    req_wdata  = 32'h22222222;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("wait_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rdata", resp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    xact(1'b0, 32'h40, 32'h0, 3'b010, 32'h11111111, 1'b0, 0);

    // Address wrap modulo array size; upper store-data bits ignored for SB
    xact(1'b1, 32'h00001050, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 0);
    xact(1'b0, 32'h50, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 0);
    xact(1'b1, 32'hFFFFF053, 32'h000001AB, 3'b000, 32'h0, 1'b0, 1);
    xact(1'b0, 32'h50, 32'h0, 3'b010, 32'hABFEF00D, 1'b0, 0);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
